// File: rtl/ternary_select_accum_pkg.sv
// Shared constants for the ternary select/accumulate datapath: kernel codes,
// default geometry and a constant-foldable ceil(log2) helper.
package ternary_select_accum_pkg;

    // Ternary kernel encodings; 2'b10 is reserved and treated as zero.
    localparam logic [1:0] KERNEL_POS  = 2'b01;
    localparam logic [1:0] KERNEL_NEG  = 2'b11;
    localparam logic [1:0] KERNEL_ZERO = 2'b00;

    localparam int unsigned DEFAULT_FEATURE_IN_WIDTH = 8;
    localparam int unsigned DEFAULT_LANES            = 4;
    localparam int unsigned DEFAULT_ACC_WIDTH        = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ternary_select_accum_lane.sv
// One ternary select lane: passes, negates or zeroes a signed feature.
// The term is one bit wider so that negating the most negative feature is exact.
module ternary_select_lane
    import ternary_select_accum_pkg::*;
#(
    parameter int unsigned FEATURE_IN_WIDTH = DEFAULT_FEATURE_IN_WIDTH
) (
    input  logic signed [FEATURE_IN_WIDTH-1:0] feature,
    input  logic        [1:0]                  kernel,
    output logic signed [FEATURE_IN_WIDTH:0]   term
);

    logic signed [FEATURE_IN_WIDTH:0] feature_ext;

    assign feature_ext = {feature[FEATURE_IN_WIDTH-1], feature};

    // Decode the kernel code into +feature, -feature or zero.
    always_comb begin
        term = '0;
        case (kernel)
            KERNEL_POS:  term = feature_ext;
            KERNEL_NEG:  term = -feature_ext;
            KERNEL_ZERO: term = '0;
            default:     term = '0;
        endcase
    end

endmodule

// File: rtl/ternary_select_accum.sv
// Multi-lane ternary select and windowed accumulator.
// S1 registers the per-lane select terms; S2 sums the lanes into the
// accumulator and, on the window's last beat, loads the output register.
// All stages advance together whenever the output slot is free or drained.
module ternary_select_accum
    import ternary_select_accum_pkg::*;
#(
    parameter int unsigned FEATURE_IN_WIDTH = DEFAULT_FEATURE_IN_WIDTH,
    parameter int unsigned LANES            = DEFAULT_LANES,
    parameter int unsigned ACC_WIDTH        = DEFAULT_ACC_WIDTH,
    parameter bit          SATURATE         = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [LANES*FEATURE_IN_WIDTH-1:0]   feature_in,
    input  logic [LANES*2-1:0]                  kernel_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                out_data,
    output logic                                out_sat
);

    localparam int unsigned TERM_W = FEATURE_IN_WIDTH + 1;
    localparam int unsigned SUM_W  = TERM_W + clog2(LANES);
    // Wide enough for acc + lane_sum even if ACC_WIDTH is narrower than SUM_W.
    localparam int unsigned WIDE_W = ((SUM_W > ACC_WIDTH) ? SUM_W : ACC_WIDTH) + 1;

    logic                              adv;
    logic                              accept;
    logic [LANES-1:0][TERM_W-1:0]      lane_terms;
    logic [LANES-1:0][TERM_W-1:0]      s1_terms;
    logic                              s1_valid;
    logic                              s1_last;
    logic signed [ACC_WIDTH-1:0]       acc;
    logic                              sticky;
    logic signed [WIDE_W-1:0]          lane_sum;
    logic signed [WIDE_W-1:0]          acc_wide;
    logic [WIDE_W-ACC_WIDTH:0]         acc_top;
    logic                              overflow;
    logic signed [ACC_WIDTH-1:0]       acc_next;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ternary_select_lane #(
            .FEATURE_IN_WIDTH(FEATURE_IN_WIDTH)
        ) u_lane (
            .feature (feature_in[i*FEATURE_IN_WIDTH +: FEATURE_IN_WIDTH]),
            .kernel  (kernel_in[i*2 +: 2]),
            .term    (lane_terms[i])
        );
    end

    // Lane adder tree, guarded accumulate and clamp/wrap of the next value.
    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + WIDE_W'($signed(s1_terms[i]));
        end
        acc_wide = WIDE_W'(acc) + lane_sum;
        acc_top  = acc_wide[WIDE_W-1:ACC_WIDTH-1];
        overflow = !((&acc_top) || (~|acc_top));
        acc_next = acc_wide[ACC_WIDTH-1:0];
        if (SATURATE && overflow) begin
            acc_next = acc_wide[WIDE_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    // S1: capture select terms and beat flags for the accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_terms <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_last  <= in_last;
            s1_terms <= lane_terms;
        end
    end

    // S2: accumulate, close windows into the output register, drain handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            if (s1_valid && s1_last) begin
                out_data  <= acc_next;
                out_sat   <= sticky || overflow;
                out_valid <= 1'b1;
                acc       <= '0;
                sticky    <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                if (s1_valid) begin
                    acc    <= acc_next;
                    sticky <= sticky || overflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_ternary_select_accum.sv
// Scoreboard bench: three instances (16-bit saturating, 10-bit saturating,
// 10-bit wrapping) share one stimulus stream; expected window results are
// queued at beat acceptance and compared when each result transfers.
module tb_ternary_select_accum;

    localparam logic [7:0] K_ALL_POS = 8'b01_01_01_01;
    localparam logic [7:0] K_ALL_RSV = 8'b10_10_10_10;
    localparam logic [7:0] K_POS0    = 8'b00_00_00_01;

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] feature_in = '0;
    logic [7:0]  kernel_in = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [15:0] out_data0;
    logic [9:0]  out_data1, out_data2;
    logic        out_sat0, out_sat1, out_sat2;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   m_acc[3];
    bit   m_st[3];
    int   m_aw[3]      = '{16, 10, 10};
    bit   m_satmode[3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    ternary_select_accum #(.FEATURE_IN_WIDTH(8), .LANES(4), .ACC_WIDTH(16), .SATURATE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .feature_in(feature_in), .kernel_in(kernel_in),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0));

    ternary_select_accum #(.FEATURE_IN_WIDTH(8), .LANES(4), .ACC_WIDTH(10), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .feature_in(feature_in), .kernel_in(kernel_in),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1));

    ternary_select_accum #(.FEATURE_IN_WIDTH(8), .LANES(4), .ACC_WIDTH(10), .SATURATE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .feature_in(feature_in), .kernel_in(kernel_in),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Reference: per-step clamp or wrap with a sticky flag, per instance.
    task automatic model_beat(input int s, input bit last);
        for (int d = 0; d < 3; d++) begin
            int mx = (1 << (m_aw[d] - 1)) - 1;
            int mn = -(1 << (m_aw[d] - 1));
            int v = m_acc[d] + s;
            bit step = 1'b0;
            exp_t e;
            if (v > mx) begin
                step = 1'b1;
                v = m_satmode[d] ? mx : v - (1 << m_aw[d]);
            end else if (v < mn) begin
                step = 1'b1;
                v = m_satmode[d] ? mn : v + (1 << m_aw[d]);
            end
            if (last) begin
                e.data = v;
                e.sat  = m_st[d] | step;
                push_exp(d, e);
                m_acc[d] = 0;
                m_st[d]  = 1'b0;
            end else begin
                m_acc[d] = v;
                m_st[d]  = m_st[d] | step;
            end
        end
    endtask

    task automatic model_flush(input bit drop_results);
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = 0;
            m_st[d]  = 1'b0;
        end
        if (drop_results) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat, wait (bounded) for acceptance, score it, then drop valid.
    task automatic send_beat(input int f[4], input logic [7:0] k, input bit last);
        int n = 0;
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] code;
            feature_in[i*8 +: 8] = 8'(f[i]);
            code = k[i*2 +: 2];
            if (code == 2'b01) s = s + f[i];
            else if (code == 2'b11) s = s - f[i];
        end
        kernel_in = k;
        in_last   = last;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            check_eq("accept_timeout", in_ready0, 1);
        end else begin
            model_beat(s, last);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && q0.size() > 0; i++) @(posedge clk);
        #1;
        check_eq(tag, q0.size() + q1.size() + q2.size(), 0);
    endtask

    // Transfer monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (rst_n && !clear && out_ready && out_valid0) begin
            exp_t e;
            check_eq("valid1", out_valid1, 1);
            check_eq("valid2", out_valid2, 1);
            check_eq("q_nonempty", (q0.size() > 0 && q1.size() > 0 && q2.size() > 0), 1);
            if (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
                e = q0.pop_front();
                check_eq("data16s", int'($signed(out_data0)), e.data);
                check_eq("sat16s", out_sat0, e.sat);
                e = q1.pop_front();
                check_eq("data10s", int'($signed(out_data1)), e.data);
                check_eq("sat10s", out_sat1, e.sat);
                e = q2.pop_front();
                check_eq("data10w", int'($signed(out_data2)), e.data);
                check_eq("sat10w", out_sat2, e.sat);
            end
        end
    end

    initial begin
        model_flush(1'b1);

        // Reset state
        #12;
        check_eq("rst_valid", out_valid0, 0);
        check_eq("rst_data", out_data0, 0);
        check_eq("rst_sat", out_sat0, 0);
        check_eq("rst_ready", in_ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-beat window with mixed codes and latency
        out_ready = 1'b1;
        send_beat('{10, -3, 7, -128}, 8'b11_00_11_01, 1'b1);
        check_eq("lat_edge1", out_valid0, 0);
        tick();
        check_eq("lat_edge2", out_valid0, 1);
        wait_drain("drain_single");

        // Multi-beat window, then a fresh window starts from zero
        send_beat('{1, 2, 3, 4}, K_ALL_POS, 1'b0);
        send_beat('{1, 2, 3, 4}, K_ALL_POS, 1'b0);
        send_beat('{1, 2, 3, 4}, K_ALL_POS, 1'b1);
        send_beat('{1, 1, 1, 1}, K_ALL_POS, 1'b1);
        wait_drain("drain_multi");

        // Overflow: clamp vs wrap, then a clean window
        send_beat('{127, 127, 127, 127}, K_ALL_POS, 1'b0);
        send_beat('{127, 127, 127, 127}, K_ALL_POS, 1'b1);
        send_beat('{1, 1, 1, 1}, K_ALL_POS, 1'b1);
        wait_drain("drain_sat");

        // Back-to-back single-beat windows give one result per cycle
        send_beat('{1, 0, 0, 0}, K_POS0, 1'b1);
        send_beat('{2, 0, 0, 0}, K_POS0, 1'b1);
        send_beat('{3, 0, 0, 0}, K_POS0, 1'b1);
        check_eq("b2b_v0", out_valid0, 1);
        tick();
        check_eq("b2b_v1", out_valid0, 1);
        tick();
        check_eq("b2b_v2", out_valid0, 0);
        wait_drain("drain_b2b");

        // Backpressure: result held stable, queued beats not lost
        out_ready = 1'b0;
        send_beat('{2, 0, 0, 0}, K_POS0, 1'b1);
        send_beat('{3, 0, 0, 0}, K_POS0, 1'b1);
        fork
            send_beat('{4, 0, 0, 0}, K_POS0, 1'b1);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check_eq("bp_ready", in_ready0, 0);
                    check_eq("bp_valid", out_valid0, 1);
                    check_eq("bp_data", int'($signed(out_data0)), 2);
                end
                tick();
                out_ready = 1'b1;
            end
        join
        wait_drain("drain_bp");

        // Clear mid-window; a beat presented with clear is dropped
        send_beat('{10, 10, 10, 10}, K_ALL_POS, 1'b0);
        send_beat('{10, 0, 0, 0}, K_POS0, 1'b0);
        tick();
        tick();
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_last    = 1'b1;
        feature_in = {8'd9, 8'd9, 8'd9, 8'd9};
        kernel_in  = K_ALL_POS;
        @(negedge clk);
        check_eq("clr_ready", in_ready0, 1);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_flush(1'b1);
        send_beat('{5, 0, 0, 0}, K_POS0, 1'b1);
        wait_drain("drain_clr");

        // Clear while a result is pending
        out_ready = 1'b0;
        send_beat('{6, 0, 0, 0}, K_POS0, 1'b1);
        tick();
        check_eq("clr_pend_valid", out_valid0, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_flush(1'b1);
        check_eq("clr_valid", out_valid0, 0);
        check_eq("clr_keep_data", int'($signed(out_data0)), 6);
        out_ready = 1'b1;
        tick();
        tick();

        // Reserved kernel code acts as zero
        send_beat('{100, 100, 100, 100}, K_ALL_RSV, 1'b1);
        wait_drain("drain_rsv");

        // Async reset mid-window, then a clean window
        send_beat('{50, 0, 0, 0}, K_POS0, 1'b1);
        wait_drain("drain_pre_rst");
        send_beat('{7, 7, 7, 7}, K_ALL_POS, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", out_valid0, 0);
        check_eq("arst_data", out_data0, 0);
        check_eq("arst_sat", out_sat0, 0);
        model_flush(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_beat('{1, 2, 3, 0}, K_ALL_POS, 1'b1);
        wait_drain("drain_post_rst");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
